spi_debug_host: RTL and testbench

- SPI initiator that drives the debug SPI port of the video core (spi_clk/spi_cs/spi_si/spi_so) from a parallel command interface.
- Each command becomes one 16-bit debug write frame (address byte, then data byte) and returns the 16 bits shifted back on MISO.
- Used in bench harnesses and by on-board bring-up logic that drives register writes into the core without the external bus.

---
 rtl/spi_debug_host.sv | 158 +++++++++++++++
 tb/tb_spi_debug_host.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_debug_host.sv
// spi_debug_host: turns a parallel address/data command into one
// 16-bit mode-0 SPI debug write frame and returns the MISO word.
module spi_debug_host #(
  parameter int HALF_DIV = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_si,
  input  logic        spi_so
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] HD_M1 = 8'(HALF_DIV - 1);
  localparam logic [7:0] GP_M1 = 8'(GAP_CYC - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_bit;
  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic [15:0] r_rdata;
  logic        r_ready;
  logic        r_busy;
  logic        r_rsp;
  logic        r_sck;
  logic        r_cs;
  logic        r_si;
  logic        r_so_meta;
  logic        r_so_sync;

  logic        w_accept;
  logic        w_cnt_end;

  assign w_accept  = cmd_valid & r_ready;
  assign w_cnt_end = (r_cnt == HD_M1);

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign spi_clk   = r_sck;
  assign spi_cs    = r_cs;
  assign spi_si    = r_si;

  // MISO is asynchronous to clk25
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_so_meta <= 1'b0;
      r_so_sync <= 1'b0;
    end else begin
      r_so_meta <= spi_so;
      r_so_sync <= r_so_meta;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_bit   <= 4'd0;
      r_tx    <= 16'd0;
      r_rx    <= 16'd0;
      r_rdata <= 16'd0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_rsp   <= 1'b0;
      r_sck   <= 1'b0;
      r_cs    <= 1'b1;
      r_si    <= 1'b0;
    end else begin
      r_rsp <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SETUP;
            r_cnt   <= 8'd0;
            r_bit   <= 4'd0;
            r_tx    <= {cmd_addr, cmd_wdata};
            r_rx    <= 16'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_si    <= cmd_addr[7];
          end
        end
        SETUP: begin
          if (w_cnt_end) begin
            r_cnt   <= 8'd0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (!w_cnt_end) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= 8'd0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else begin
              r_sck <= 1'b0;
              r_rx  <= {r_rx[14:0], r_so_sync};
              if (r_bit == 4'd15) begin
                r_state <= HOLD;
              end else begin
                r_bit <= r_bit + 4'd1;
                r_tx  <= r_tx << 1;
                r_si  <= r_tx[14];
              end
            end
          end
        end
        HOLD: begin
          if (w_cnt_end) begin
            r_cnt   <= 8'd0;
            r_state <= GAP;
            r_cs    <= 1'b1;
            r_si    <= 1'b0;
            r_rsp   <= 1'b1;
            r_rdata <= r_rx;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        GAP: begin
          if (r_cnt == GP_M1) begin
            r_cnt   <= 8'd0;
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_debug_host.sv
// tb_spi_debug_host: three divider configurations driven with random
// frames and checked against a frame-level model of the SPI protocol.
module tb_spi_debug_host;

  localparam int HDV[3] = '{2, 3, 7};
  localparam int GPV[3] = '{4, 4, 1};

  logic        clk25 = 1'b0;
  logic        reset_n;
  logic        cv[3];
  logic        rdy[3];
  logic        rv[3];
  logic        bsy[3];
  logic        sck[3];
  logic        cs[3];
  logic        si[3];
  logic        so[3];
  logic [7:0]  ca[3];
  logic [7:0]  cw[3];
  logic [15:0] rd[3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_t[3] = '{0, 0, 0};
  int acc_n[3] = '{0, 0, 0};

  always #5 clk25 = ~clk25;

  spi_debug_host #(.HALF_DIV(2), .GAP_CYC(4)) u0 (
    .clk25(clk25), .reset_n(reset_n),
    .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_addr(ca[0]), .cmd_wdata(cw[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .busy(bsy[0]), .spi_clk(sck[0]),
    .spi_cs(cs[0]), .spi_si(si[0]), .spi_so(so[0])
  );

  spi_debug_host #(.HALF_DIV(3), .GAP_CYC(4)) u1 (
    .clk25(clk25), .reset_n(reset_n),
    .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_addr(ca[1]), .cmd_wdata(cw[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .busy(bsy[1]), .spi_clk(sck[1]),
    .spi_cs(cs[1]), .spi_si(si[1]), .spi_so(so[1])
  );

  spi_debug_host #(.HALF_DIV(7), .GAP_CYC(1)) u2 (
    .clk25(clk25), .reset_n(reset_n),
    .cmd_valid(cv[2]), .cmd_ready(rdy[2]),
    .cmd_addr(ca[2]), .cmd_wdata(cw[2]),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
    .busy(bsy[2]), .spi_clk(sck[2]),
    .spi_cs(cs[2]), .spi_si(si[2]), .spi_so(so[2])
  );

  always @(posedge clk25) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (cv[i] && rdy[i]) begin
        acc_t[i] <= cyc;
        acc_n[i] <= acc_n[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on instance i: slave model returns m, next command staged.
  task automatic run_frame(input int i, input logic [7:0] a,
                           input logic [7:0] d, input logic [15:0] m,
                           input bit keep, input logic [7:0] na,
                           input logic [7:0] nd);
    int hd, lim, rises, run, csl, rsp_k, rdy_k, pulses, bad, jb;
    logic lvl, prev, was_low, tailed, done;
    logic [15:0] mosi, got;
    hd = HDV[i];
    rises = 0; run = 0; csl = 0; rsp_k = 0; rdy_k = 0;
    pulses = 0; bad = 0; jb = 0;
    lvl = 1'b0; prev = 1'b0; was_low = 1'b0;
    tailed = 1'b0; done = 1'b0;
    mosi = 16'd0; got = 16'd0;
    chk("pre_ready", 32'(rdy[i]), 1);
    ca[i] = a;
    cw[i] = d;
    cv[i] = 1'b1;
    @(posedge clk25);
    lim = 34 * hd + GPV[i] + 20;
    for (int k = 1; k <= lim && !done; k++) begin
      @(negedge clk25);
      if (k == 1) begin
        cv[i] = keep;
        ca[i] = na;
        cw[i] = nd;
        so[i] = m[15];
        jb = 1;
        chk("busy", 32'(bsy[i]), 1);
      end
      if (!cs[i]) begin
        csl++;
        if (!was_low) begin
          was_low = 1'b1;
          lvl = sck[i];
          run = 1;
        end else if (sck[i] == lvl) begin
          run++;
        end else begin
          if (lvl) begin
            if (run != hd) bad++;
          end else begin
            if (run != ((rises == 0) ? 2 * hd : hd)) bad++;
          end
          lvl = sck[i];
          run = 1;
        end
      end else if (was_low && !tailed) begin
        tailed = 1'b1;
        if (lvl || run != hd) bad++;
      end
      if (cs[i] && sck[i]) bad++;
      if (sck[i] && !prev) begin
        rises++;
        mosi = {mosi[14:0], si[i]};
      end
      if (!sck[i] && prev) begin
        if (jb < 16) so[i] = m[15 - jb];
        jb++;
      end
      prev = sck[i];
      if (rv[i]) begin
        pulses++;
        if (rsp_k == 0) begin
          rsp_k = k;
          got = rd[i];
        end
      end
      if (rdy[i]) begin
        done = 1'b1;
        rdy_k = k;
      end
    end
    chk("timeout", 32'(done), 1);
    chk("cs_low", csl, 34 * hd);
    chk("rises", rises, 16);
    chk("mosi", 32'(mosi), 32'({a, d}));
    chk("phase", bad, 0);
    chk("rsp_cyc", rsp_k, 34 * hd + 1);
    chk("rsp_pulses", pulses, 1);
    chk("rdata", 32'(got), 32'(m));
    chk("rdata_hold", 32'(rd[i]), 32'(m));
    chk("ready_cyc", rdy_k, 34 * hd + GPV[i] + 1);
    chk("busy_idle", 32'(bsy[i]), 0);
    so[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0, r, pulses;
    logic p;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cv[i] = 1'b0; so[i] = 1'b0;
      ca[i] = 8'h00; cw[i] = 8'h00;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk25);
      for (int i = 0; i < 3; i++) begin
        cv[i] = ~cv[i];
        ca[i] = 8'(j + 1);
      end
    end
    @(negedge clk25);
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs", 32'(cs[i]), 1);
      chk("rst_sck", 32'(sck[i]), 0);
      chk("rst_ready", 32'(rdy[i]), 1);
      chk("rst_rsp", 32'(rv[i]), 0);
    end
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_si", 32'(si[0]), 0);
    chk("rst_rdata", 32'(rd[0]), 0);
    for (int i = 0; i < 3; i++) cv[i] = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk25);

    run_frame(0, 8'h1F, 8'hA5, 16'hC3F0, 1'b0, 8'h00, 8'h00);

    run_frame(0, 8'h00, 8'h11, 16'($urandom), 1'b1, 8'h01, 8'h22);
    t0 = acc_t[0];
    n0 = acc_n[0];
    run_frame(0, 8'h01, 8'h22, 16'($urandom), 1'b0, 8'h00, 8'h00);
    chk("b2b_gap", acc_t[0] - t0, 73);
    chk("b2b_cnt", acc_n[0] - n0, 1);

    run_frame(1, 8'h80, 8'h01, 16'h8001, 1'b0, 8'h00, 8'h00);
    run_frame(2, 8'h80, 8'h01, 16'hFFFF, 1'b0, 8'h00, 8'h00);

    repeat (3) @(negedge clk25);
    ca[0] = 8'h5A;
    cw[0] = 8'h3C;
    cv[0] = 1'b1;
    @(posedge clk25);
    r = 0;
    p = 1'b0;
    for (int k = 0; k < 200 && r < 5; k++) begin
      @(negedge clk25);
      cv[0] = 1'b0;
      if (sck[0] && !p) r++;
      p = sck[0];
    end
    chk("abort_rises", r, 5);
    reset_n = 1'b0;
    #1;
    chk("abort_cs", 32'(cs[0]), 1);
    chk("abort_sck", 32'(sck[0]), 0);
    chk("abort_ready", 32'(rdy[0]), 1);
    chk("abort_rdata", 32'(rd[0]), 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk25);
      if (rv[0]) pulses++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk25);
      if (rv[0]) pulses++;
    end
    chk("abort_rsp", pulses, 0);
    run_frame(0, 8'hE7, 8'h18, 16'h5AA5, 1'b0, 8'h00, 8'h00);

    for (int n = 0; n < 24; n++) begin
      int i;
      i = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clk25);
      run_frame(i, 8'($urandom), 8'($urandom), 16'($urandom),
                1'b0, 8'h00, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
